bus_ctrl: RTL and testbench

68000 bus-cycle controller in the glue logic, directly upstream of the ROM, RAM and I/O-port slaves. It decodes each CPU bus cycle into one active-high slave enable and converts the CPU strobes into active-high slave strobes. It returns the slaves' active-low DTACK/BERR to the CPU. It ends the cycle itself with BERR when the address is unmapped or no slave answers in time, and with VPA on interrupt-acknowledge cycles.

---
 rtl/glue_pkg.sv | 45 ++++
 rtl/bus_watchdog.sv | 38 +++
 rtl/bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glue_pkg.sv
// Shared definitions for the 68000 glue logic.
//   state_e        : bus-cycle controller states
//   region_e       : decoded target of a CPU bus cycle
//   *_BASE/*_LIMIT : byte-address bounds of the mapped regions
//   FC_IACK        : function code of an interrupt-acknowledge cycle
//   decode_region(): maps (fc, A[23:1]) onto a region
package glue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    WAIT,
    TERM
  } state_e;

  typedef enum logic [2:0] {
    NONE,
    ROM,
    RAM,
    IO,
    IACK
  } region_e;

  // Byte addresses. ROM starts at 0 and IO runs to the top of the 24-bit
  // space, so only the bounds that can actually exclude an address are kept.
  localparam logic [23:0] ROM_LIMIT = 24'h0F_FFFF;
  localparam logic [23:0] RAM_BASE  = 24'h10_0000;
  localparam logic [23:0] RAM_LIMIT = 24'h7F_FFFF;
  localparam logic [23:0] IO_BASE   = 24'hFF_FE00;

  localparam logic [2:0] FC_IACK = 3'b111;

  function automatic region_e decode_region(input logic [2:0]  fc,
                                            input logic [22:0] addr);
    logic [23:0] byte_addr;
    byte_addr = {addr, 1'b0};
    // An interrupt acknowledge overrides the memory map entirely.
    if (fc == FC_IACK)                                        return IACK;
    else if (byte_addr <= ROM_LIMIT)                          return ROM;
    else if (byte_addr >= RAM_BASE && byte_addr <= RAM_LIMIT) return RAM;
    else if (byte_addr >= IO_BASE)                            return IO;
    else                                                      return NONE;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Down-counter that bounds how long a slave may take to answer.
//   clk, reset_n : clock, asynchronous active-low reset (count -> 0)
//   load, value  : load the counter with value (load wins over run)
//   run          : decrement by one per cycle, stopping at zero
//   expired      : counter currently at zero
module bus_watchdog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = value;
    else if (run && count_q != '0)
      count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/bus_ctrl.sv
// 68000 bus-cycle controller: decodes each CPU cycle into one slave enable,
// converts CPU strobes to active-high slave strobes and terminates the cycle
// with DTACK, BERR (slave error, unmapped, watchdog) or VPA (IACK).
//   clk, reset_n                   : clock, asynchronous active-low reset
//   as_n, rw, uds_n, lds_n, fc     : CPU bus-cycle controls
//   addr                           : CPU A[23:1]
//   dtack_n, berr_n                : shared slave terminations (active low)
//   rom_en, ram_en, io_en          : slave selects, one-hot or all zero
//   write, uds, lds                : slave strobes, active high
//   io_addr                        : A[8:1] for the I/O port (combinational)
//   cpu_dtack_n/berr_n/vpa_n       : CPU terminations (active low)
module bus_ctrl
  import glue_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        rw,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [2:0]  fc,
  input  logic [22:0] addr,
  input  logic        dtack_n,
  input  logic        berr_n,
  output logic        rom_en,
  output logic        ram_en,
  output logic        io_en,
  output logic        write,
  output logic        uds,
  output logic        lds,
  output logic [7:0]  io_addr,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic        cpu_vpa_n
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_e  state_q, state_d;
  region_e region;

  logic rom_en_q, rom_en_d, ram_en_q, ram_en_d, io_en_q, io_en_d;
  logic write_q, write_d, uds_q, uds_d, lds_q, lds_d;
  logic dtack_n_q, dtack_n_d, berr_n_q, berr_n_d, vpa_n_q, vpa_n_d;
  logic wd_load, wd_run, wd_expired;

  assign region = decode_region(fc, addr);

  bus_watchdog #(.WIDTH(8)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (wd_load),
    .value   (TIMEOUT_M1),
    .run     (wd_run),
    .expired (wd_expired)
  );

  assign wd_run = (state_q == WAIT);

  always_comb begin
    state_d   = state_q;
    rom_en_d  = rom_en_q;
    ram_en_d  = ram_en_q;
    io_en_d   = io_en_q;
    write_d   = write_q;
    uds_d     = uds_q;
    lds_d     = lds_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    vpa_n_d   = vpa_n_q;
    wd_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!as_n) state_d = DECODE;
      end

      DECODE: begin
        if (as_n) begin
          state_d = IDLE;
        end else begin
          write_d = ~rw;
          uds_d   = ~uds_n;
          lds_d   = ~lds_n;
          unique case (region)
            IACK: begin state_d = TERM; vpa_n_d  = 1'b0; end
            NONE: begin state_d = TERM; berr_n_d = 1'b0; end
            ROM:  begin state_d = WAIT; rom_en_d = 1'b1; wd_load = 1'b1; end
            RAM:  begin state_d = WAIT; ram_en_d = 1'b1; wd_load = 1'b1; end
            IO:   begin state_d = WAIT; io_en_d  = 1'b1; wd_load = 1'b1; end
            default: state_d = IDLE;
          endcase
        end
      end

      WAIT: begin
        // Priority: abort, slave BERR, slave DTACK, then watchdog. A slave
        // answering on the expiry edge therefore beats the watchdog.
        if (as_n) begin
          state_d = IDLE;
        end else if (!berr_n) begin
          state_d  = TERM;
          berr_n_d = 1'b0;
        end else if (!dtack_n) begin
          state_d   = TERM;
          dtack_n_d = 1'b0;
        end else if (wd_expired) begin
          state_d  = TERM;
          berr_n_d = 1'b0;
        end
      end

      TERM: begin
        if (as_n) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Whatever the path into IDLE (end of cycle or abort), every output
    // releases on that same edge.
    if (state_d == IDLE) begin
      rom_en_d  = 1'b0;
      ram_en_d  = 1'b0;
      io_en_d   = 1'b0;
      write_d   = 1'b0;
      uds_d     = 1'b0;
      lds_d     = 1'b0;
      dtack_n_d = 1'b1;
      berr_n_d  = 1'b1;
      vpa_n_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rom_en_q  <= 1'b0;
      ram_en_q  <= 1'b0;
      io_en_q   <= 1'b0;
      write_q   <= 1'b0;
      uds_q     <= 1'b0;
      lds_q     <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      vpa_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      rom_en_q  <= rom_en_d;
      ram_en_q  <= ram_en_d;
      io_en_q   <= io_en_d;
      write_q   <= write_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      vpa_n_q   <= vpa_n_d;
    end
  end

  assign rom_en      = rom_en_q;
  assign ram_en      = ram_en_q;
  assign io_en       = io_en_q;
  assign write       = write_q;
  assign uds         = uds_q;
  assign lds         = lds_q;
  assign cpu_dtack_n = dtack_n_q;
  assign cpu_berr_n  = berr_n_q;
  assign cpu_vpa_n   = vpa_n_q;
  assign io_addr     = addr[7:0];

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl. Each CPU cycle is described as a
// transaction (address, strobes, when/how the slave answers, abort point);
// the expected outputs after every clock edge are computed from that
// description using the memory map and the termination rules.
module tb_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        as_n = 1'b1, rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [2:0]  fc = 3'd5;
  logic [22:0] addr = '0;
  logic        dtack_n = 1'b1, berr_n = 1'b1;
  logic        rom_en, ram_en, io_en, write, uds, lds;
  logic [7:0]  io_addr;
  logic        cpu_dtack_n, cpu_berr_n, cpu_vpa_n;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [8:0] IDLE_OUT = 9'b000000_111;

  typedef struct {
    logic [2:0]  fc;
    logic [23:0] baddr;
    logic        rw, uds_n, lds_n;
    int          s_edge;     // edge at which the slave is first sampled low (0 = never)
    int          s_kind;     // 1 dtack, 2 berr, 3 both
    int          abort_edge; // edge sampling as_n high before termination (0 = none)
    int          hold;       // edges between termination and as_n sampled high
    int          noise;      // slave glitch sampled at E1 (0 = none)
  } txn_t;

  bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw), .uds_n(uds_n),
    .lds_n(lds_n), .fc(fc), .addr(addr), .dtack_n(dtack_n), .berr_n(berr_n),
    .rom_en(rom_en), .ram_en(ram_en), .io_en(io_en), .write(write),
    .uds(uds), .lds(lds), .io_addr(io_addr), .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n(cpu_berr_n), .cpu_vpa_n(cpu_vpa_n)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // 0 unmapped, 1 ROM, 2 RAM, 3 IO, 4 IACK
  function automatic int region_of(input txn_t t);
    if (t.fc == 3'b111)                                return 4;
    if (t.baddr <= 24'h0FFFFF)                         return 1;
    if (t.baddr >= 24'h100000 && t.baddr <= 24'h7FFFFF) return 2;
    if (t.baddr >= 24'hFFFE00)                         return 3;
    return 0;
  endfunction

  // Edge at which the CPU termination appears and its kind (0 dtack, 1 berr, 2 vpa).
  function automatic void term_of(input txn_t t, output int e, output int kind);
    int r;
    r = region_of(t);
    if (r == 4)      begin e = 1; kind = 2; end
    else if (r == 0) begin e = 1; kind = 1; end
    else if (t.s_edge >= 2 && t.s_edge <= 1 + TO) begin
      e = t.s_edge;
      kind = ((t.s_kind & 2) != 0) ? 1 : 0;
    end else begin
      e = 1 + TO;
      kind = 1;
    end
  endfunction

  function automatic int end_of(input txn_t t);
    int e, kind;
    term_of(t, e, kind);
    return (t.abort_edge > 0) ? t.abort_edge : e + t.hold;
  endfunction

  // {rom,ram,io,write,uds,lds,cpu_dtack_n,cpu_berr_n,cpu_vpa_n} after edge k.
  function automatic logic [8:0] expect_at(input txn_t t, input int k);
    logic [8:0] v;
    int r, te, kind, e_end;
    v = IDLE_OUT;
    r = region_of(t);
    term_of(t, te, kind);
    e_end = end_of(t);
    if (k < 1 || k >= e_end) return v;
    v[8] = (r == 1);
    v[7] = (r == 2);
    v[6] = (r == 3);
    v[5] = !t.rw;
    v[4] = !t.uds_n;
    v[3] = !t.lds_n;
    if (k >= te) v[2 - kind] = 1'b0;
    return v;
  endfunction

  // ---------------- drivers ----------------
  function automatic logic [8:0] observed();
    return {rom_en, ram_en, io_en, write, uds, lds, cpu_dtack_n, cpu_berr_n, cpu_vpa_n};
  endfunction

  task automatic drive_slave(input int kind);
    dtack_n = ((kind & 1) != 0) ? 1'b0 : 1'b1;
    berr_n  = ((kind & 2) != 0) ? 1'b0 : 1'b1;
  endtask

  task automatic run_txn(input txn_t t, input string name);
    int e_end;
    logic [8:0] obs, exp;
    logic [7:0] exp_io;
    e_end  = end_of(t);
    exp_io = t.baddr[8:1];
    @(negedge clk);
    fc = t.fc; addr = t.baddr[23:1]; rw = t.rw; uds_n = t.uds_n; lds_n = t.lds_n;
    as_n = 1'b0;
    drive_slave(0);
    for (int k = 0; k <= e_end + 1; k++) begin
      @(posedge clk);
      #1;
      obs = observed();
      exp = expect_at(t, k);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s edge E%0d: outputs %b, expected %b", name, k, obs, exp);
      end
      n_cmp++;
      if (io_addr !== exp_io) begin
        n_bad++;
        $display("FAIL %s io_addr edge E%0d: got %h, expected %h", name, k, io_addr, exp_io);
      end
      @(negedge clk);
      as_n = (k + 1 >= e_end);
      if (t.noise != 0 && k + 1 == 1)
        drive_slave(t.noise);
      else if (t.s_edge > 0 && k + 1 >= t.s_edge && k + 1 < e_end)
        drive_slave(t.s_kind);
      else
        drive_slave(0);
    end
  endtask

  function automatic txn_t mk(input logic [2:0] f, input logic [23:0] a, input logic r,
                              input logic u, input logic l, input int se, input int sk,
                              input int ab, input int hd, input int nz);
    txn_t t;
    t.fc = f; t.baddr = a; t.rw = r; t.uds_n = u; t.lds_n = l;
    t.s_edge = se; t.s_kind = sk; t.abort_edge = ab; t.hold = hd; t.noise = nz;
    return t;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_async: outputs %b, expected %b", observed(), IDLE_OUT);
    end
    as_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (observed() !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_held: outputs %b, expected %b", observed(), IDLE_OUT);
    end
    @(negedge clk) as_n = 1'b1;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_rom_read();
    // dtack 3 cycles after rom_en; dtack+berr glitch at E1 must be ignored.
    run_txn(mk(3'd6, 24'h000400, 1'b1, 1'b0, 1'b0, 4, 1, 0, 2, 3), "rom_read");
  endtask

  task automatic test_io_write_berr();
    run_txn(mk(3'd5, 24'hFFFE10, 1'b0, 1'b0, 1'b0, 3, 2, 0, 1, 0), "io_write_berr");
  endtask

  task automatic test_unmapped();
    run_txn(mk(3'd5, 24'h900000, 1'b1, 1'b0, 1'b1, 0, 1, 0, 2, 0), "unmapped");
  endtask

  task automatic test_ram_timeout();
    run_txn(mk(3'd1, 24'h100000, 1'b1, 1'b0, 1'b0, 0, 1, 0, 2, 0), "ram_timeout");
  endtask

  task automatic test_iack();
    run_txn(mk(3'd7, 24'hFFFFF0, 1'b1, 1'b1, 1'b0, 2, 1, 0, 2, 0), "iack");
  endtask

  task automatic test_both_terms();
    run_txn(mk(3'd5, 24'h200000, 1'b0, 1'b1, 1'b0, 3, 3, 0, 1, 0), "dtack_berr_same");
  endtask

  task automatic test_tie_with_timeout();
    run_txn(mk(3'd5, 24'h7FFFFE, 1'b1, 1'b0, 1'b0, 1 + TO, 1, 0, 1, 0), "tie_timeout");
    run_txn(mk(3'd5, 24'h0FFFFE, 1'b1, 1'b0, 1'b0, 2 + TO, 1, 0, 1, 0), "slave_too_late");
  endtask

  task automatic test_abort();
    run_txn(mk(3'd5, 24'h300000, 1'b1, 1'b0, 1'b0, 0, 1, 3, 1, 0), "abort_wait");
    run_txn(mk(3'd5, 24'h000010, 1'b0, 1'b0, 1'b0, 0, 1, 1, 1, 0), "abort_decode");
    run_txn(mk(3'd5, 24'h000020, 1'b1, 1'b0, 1'b0, 3, 1, 0, 1, 0), "after_abort");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    fc = 3'd5; addr = 23'(24'h400000 >> 1); rw = 1'b0; uds_n = 1'b0; lds_n = 1'b1;
    as_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (observed() !== 9'b010_110_111) begin
      n_bad++;
      $display("FAIL reset_mid_wait pre: outputs %b, expected %b", observed(), 9'b010_110_111);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_mid_wait: outputs %b, expected %b", observed(), IDLE_OUT);
    end
    @(negedge clk) as_n = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    run_txn(mk(3'd5, 24'h400000, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 0), "after_reset");
  endtask

  task automatic gen(output txn_t t);
    int te, kind;
    t.fc = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(1, 6));
    case ($urandom_range(0, 3))
      0:       t.baddr = 24'($urandom_range(0, 24'h0FFFFF));
      1:       t.baddr = 24'($urandom_range(24'h100000, 24'h7FFFFF));
      2:       t.baddr = 24'($urandom_range(24'hFFFE00, 24'hFFFFFF));
      default: t.baddr = 24'($urandom_range(24'h800000, 24'hFFFDFF));
    endcase
    t.baddr[0] = 1'b0;
    t.rw    = 1'($urandom_range(0, 1));
    t.uds_n = 1'($urandom_range(0, 1));
    t.lds_n = 1'($urandom_range(0, 1));
    t.s_edge = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, TO + 3));
    t.s_kind = int'($urandom_range(1, 3));
    t.noise  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    t.hold   = int'($urandom_range(1, 3));
    t.abort_edge = 0;
    if ($urandom_range(0, 5) == 0) begin
      term_of(t, te, kind);
      t.abort_edge = int'($urandom_range(1, te));
    end
  endtask

  task automatic test_random(input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      gen(t);
      run_txn(t, $sformatf("random%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_txn(mk(3'd5, 24'h000100, 1'b1, 1'b0, 1'b0, 2, 1, 0, 1, 0), "b2b_rom");
    run_txn(mk(3'd5, 24'hFFFE02, 1'b0, 1'b1, 1'b0, 2, 1, 0, 1, 0), "b2b_io");
    run_txn(mk(3'd7, 24'hFFFFFE, 1'b1, 1'b1, 1'b0, 0, 1, 0, 1, 0), "b2b_iack");
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_io_write_berr();
    test_unmapped();
    test_ram_timeout();
    test_iack();
    test_both_terms();
    test_tie_with_timeout();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
